frame_buffer_scheduler: RTL and testbench

//  Triple-buffer scheduler for the camera->DDR->HDMI frame store. Hands the AXI writer and AXI

---
 rtl/frame_buffer_scheduler.sv | 122 ++++++++++++
 tb/tb_frame_buffer_scheduler.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_scheduler.sv
// Triple-buffer scheduler: rotates three DDR frame buffers between an
// AXI writer and reader. Ports: clk/reset, sched_en, frame events in;
// writer/reader base addresses, swap pulses, drop/repeat counters out.
module frame_buffer_scheduler #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter logic [31:0] FRAME_BYTES = 32'd614400,
  parameter int          CNT_W       = 16
) (
  input  logic             clk_100Mhz,
  input  logic             sys_rst_n,
  input  logic             sched_en,
  input  logic             wr_frame_done,
  input  logic             rd_frame_start,
  output logic [31:0]      wr_base_addr,
  output logic [31:0]      rd_base_addr,
  output logic             wr_swap,
  output logic             rd_swap,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] repeat_cnt
);

  logic             wd_q, rs_q;
  logic [1:0]       wr_idx_q, wr_idx_d;
  logic [1:0]       rd_idx_q, rd_idx_d;
  logic [1:0]       rdy_idx_q, rdy_idx_d;
  logic             rdy_valid_q, rdy_valid_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [31:0]      wr_addr_q, rd_addr_q;
  logic             wr_swap_q, wr_swap_d;
  logic             rd_swap_q, rd_swap_d;

  logic       wd_ev, rs_ev;
  logic [1:0] free_idx;

  function automatic logic [31:0] addr_of(input logic [1:0] idx);
    return BASE_ADDR + 32'(idx) * FRAME_BYTES;
  endfunction

  assign wd_ev = sched_en & wr_frame_done & ~wd_q;
  assign rs_ev = sched_en & rd_frame_start & ~rs_q;

  // indices are a permutation of {0,1,2}: the unused one is 3 - a - b
  assign free_idx = 2'd3 - wr_idx_q - rd_idx_q;

  always_comb begin
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    rdy_idx_d   = rdy_idx_q;
    rdy_valid_d = rdy_valid_q;
    drop_d      = drop_q;
    rep_d       = rep_q;
    wr_swap_d   = 1'b0;
    rd_swap_d   = 1'b0;
    if (wd_ev && rdy_valid_q && drop_q != '1)
      drop_d = drop_q + CNT_W'(1);
    unique case (1'b1)
      wd_ev & rs_ev: begin
        // fresh frame goes straight to the reader
        rd_idx_d    = wr_idx_q;
        rdy_valid_d = 1'b0;
        wr_idx_d    = free_idx;
        wr_swap_d   = 1'b1;
        rd_swap_d   = 1'b1;
      end
      wd_ev & ~rs_ev: begin
        rdy_idx_d   = wr_idx_q;
        rdy_valid_d = 1'b1;
        wr_idx_d    = free_idx;
        wr_swap_d   = 1'b1;
      end
      rs_ev & ~wd_ev: begin
        if (rdy_valid_q) begin
          rd_idx_d    = rdy_idx_q;
          rdy_valid_d = 1'b0;
          rd_swap_d   = 1'b1;
        end else if (rep_q != '1) begin
          rep_d = rep_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_100Mhz) begin
    if (!sys_rst_n) begin
      wd_q        <= 1'b0;
      rs_q        <= 1'b0;
      wr_idx_q    <= 2'd0;
      rd_idx_q    <= 2'd1;
      rdy_idx_q   <= 2'd2;
      rdy_valid_q <= 1'b0;
      drop_q      <= '0;
      rep_q       <= '0;
      wr_addr_q   <= BASE_ADDR;
      rd_addr_q   <= BASE_ADDR + FRAME_BYTES;
      wr_swap_q   <= 1'b0;
      rd_swap_q   <= 1'b0;
    end else begin
      wd_q        <= wr_frame_done;
      rs_q        <= rd_frame_start;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      rdy_idx_q   <= rdy_idx_d;
      rdy_valid_q <= rdy_valid_d;
      drop_q      <= drop_d;
      rep_q       <= rep_d;
      wr_addr_q   <= addr_of(wr_idx_d);
      rd_addr_q   <= addr_of(rd_idx_d);
      wr_swap_q   <= wr_swap_d;
      rd_swap_q   <= rd_swap_d;
    end
  end

  assign wr_base_addr = wr_addr_q;
  assign rd_base_addr = rd_addr_q;
  assign wr_swap      = wr_swap_q;
  assign rd_swap      = rd_swap_q;
  assign drop_cnt     = drop_q;
  assign repeat_cnt   = rep_q;

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Bench for frame_buffer_scheduler: directed scenarios with literal
// expectations, then random events checked against a buffer-pool model.
module tb_frame_buffer_scheduler;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] FB   = 32'd614400;
  localparam int          CW   = 2;
  localparam int          CMAX = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b1;
  logic          wd = 1'b0;
  logic          rs = 1'b0;
  logic [31:0]   wr_base, rd_base;
  logic          wr_sw, rd_sw;
  logic [CW-1:0] drop, rep;

  int vectors = 0;
  int miscompares = 0;

  // model state: which buffer each party owns, -1 = none ready
  int m_wr, m_rd, m_rdy, m_drop, m_rep;
  bit m_wsw, m_rsw, p_wd, p_rs;

  frame_buffer_scheduler #(
    .BASE_ADDR  (BASE),
    .FRAME_BYTES(FB),
    .CNT_W      (CW)
  ) dut (
    .clk_100Mhz    (clk),
    .sys_rst_n     (rst_n),
    .sched_en      (en),
    .wr_frame_done (wd),
    .rd_frame_start(rs),
    .wr_base_addr  (wr_base),
    .rd_base_addr  (rd_base),
    .wr_swap       (wr_sw),
    .rd_swap       (rd_sw),
    .drop_cnt      (drop),
    .repeat_cnt    (rep)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp,
               $time);
    end
  endtask

  function automatic int unused_buf(input int a, input int b);
    for (int i = 0; i < 3; i++)
      if (i != a && i != b) return i;
    return -1;
  endfunction

  function automatic logic [31:0] addr(input int idx);
    return BASE + FB * 32'(idx);
  endfunction

  function automatic int bump(input int c);
    return (c < CMAX) ? c + 1 : c;
  endfunction

  always @(posedge clk) begin
    bit we, re;
    int ow;
    m_wsw = 0;
    m_rsw = 0;
    if (!rst_n) begin
      m_wr = 0; m_rd = 1; m_rdy = -1;
      m_drop = 0; m_rep = 0;
      p_wd = 0; p_rs = 0;
    end else begin
      we = wd && !p_wd;
      re = rs && !p_rs;
      p_wd = wd;
      p_rs = rs;
      if (en) begin
        ow = m_wr;
        if (we) begin
          if (m_rdy >= 0) m_drop = bump(m_drop);
          m_wr = unused_buf(ow, m_rd);
          m_wsw = 1;
          if (re) begin
            m_rd = ow; m_rdy = -1; m_rsw = 1;
          end else begin
            m_rdy = ow;
          end
        end else if (re) begin
          if (m_rdy >= 0) begin
            m_rd = m_rdy; m_rdy = -1; m_rsw = 1;
          end else begin
            m_rep = bump(m_rep);
          end
        end
      end
    end
    #1;
    chk("wr_base", wr_base, addr(m_wr));
    chk("rd_base", rd_base, addr(m_rd));
    chk("wr_swap", 32'(wr_sw), 32'(m_wsw));
    chk("rd_swap", 32'(rd_sw), 32'(m_rsw));
    chk("drop_cnt", 32'(drop), 32'(m_drop));
    chk("repeat_cnt", 32'(rep), 32'(m_rep));
    chk("idx_distinct", 32'(wr_base != rd_base), 32'd1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; wd = 0; rs = 0; en = 1;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic pulse(input bit w, input bit r);
    @(negedge clk);
    wd = w; rs = r;
    @(negedge clk);
    wd = 0; rs = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    chk("t1_wr", wr_base, 32'h1000_0000);
    chk("t1_rd", rd_base, 32'h1009_6000);
    chk("t1_sw", {30'd0, wr_sw, rd_sw}, 32'd0);
    chk("t1_cnt", {28'd0, drop, rep}, 32'd0);

    pulse(1, 0);
    chk("t2_wr", wr_base, 32'h1012_C000);
    chk("t2_wsw", 32'(wr_sw), 32'd1);
    repeat (9) @(negedge clk);
    pulse(0, 1);
    chk("t2_rd", rd_base, 32'h1000_0000);
    chk("t2_rsw", 32'(rd_sw), 32'd1);
    chk("t2_cnt", {28'd0, drop, rep}, 32'd0);

    do_reset();
    pulse(1, 0);
    pulse(1, 0);
    chk("t3_drop", 32'(drop), 32'd1);
    chk("t3_wr", wr_base, 32'h1000_0000);
    pulse(0, 1);
    chk("t3_rd", rd_base, 32'h1012_C000);
    pulse(0, 1);
    chk("t4_rep", 32'(rep), 32'd1);
    chk("t4_rd", rd_base, 32'h1012_C000);
    chk("t4_rsw", 32'(rd_sw), 32'd0);

    do_reset();
    pulse(1, 1);
    chk("t5_rd", rd_base, 32'h1000_0000);
    chk("t5_wr", wr_base, 32'h1012_C000);
    chk("t5_sw", {30'd0, wr_sw, rd_sw}, 32'd3);

    do_reset();
    @(negedge clk);
    wd = 1;
    @(negedge clk);
    chk("t6_wr1", wr_base, 32'h1012_C000);
    repeat (49) @(negedge clk);
    chk("t6_held", wr_base, 32'h1012_C000);
    chk("t6_drop", 32'(drop), 32'd0);
    wd = 0; en = 0;
    @(negedge clk);
    wd = 1;
    repeat (2) @(negedge clk);
    en = 1;
    repeat (3) @(negedge clk);
    chk("t6_lost", wr_base, 32'h1012_C000);
    wd = 0;
    repeat (5) pulse(1, 0);
    chk("t6_sat", 32'(drop), 32'd3);
    rst_n = 0;
    @(negedge clk);
    chk("t6_rst_wr", wr_base, 32'h1000_0000);
    chk("t6_rst_cnt", {28'd0, drop, rep}, 32'd0);
    rst_n = 1;

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      wd    = ($urandom_range(0, 3) == 0);
      rs    = ($urandom_range(0, 3) == 0);
      en    = ($urandom_range(0, 9) != 0);
      rst_n = ($urandom_range(0, 199) != 0);
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule
